// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, issue FSM states and
// instruction field positions for the {op, rd, rs1, rs2} encoding.
package alu_pkg;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_MUL  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } issue_state_e;

    // rs2 sits at bit 0; the other fields stack above it, op on top.
    function automatic int instr_width(input int aw);
        return 2 + 3 * aw;
    endfunction

    function automatic int rs1_lsb(input int aw);
        return aw;
    endfunction

    function automatic int rd_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int op_lsb(input int aw);
        return 3 * aw;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue stage: two operand read ports, one debug read
// port, one write port, and a synchronous active-low clear of every entry.
module alu_regfile #(
    parameter int N      = 12,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [N-1:0]      wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [N-1:0]      rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [N-1:0]      rdata2_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [N-1:0]      dbg_data_o
);

    logic [N-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = mem_q[raddr1_i];
    assign rdata2_o   = mem_q[raddr2_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue front end for the clocked ALU: reads operands, waits out the ALU
// latency, writes the result back. Define ALU_ISSUE_PERF_CNT_EN for perf_count.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int N          = 12,
    parameter int REG_ADDR_W = 3,
    parameter int ALU_LAT    = 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 instr_valid,
    output logic                                 instr_ready,
    input  logic [instr_width(REG_ADDR_W)-1:0]   instr,
    input  logic                                 ld_en,
    output logic                                 ld_ready,
    input  logic [REG_ADDR_W-1:0]                ld_addr,
    input  logic [N-1:0]                         ld_data,
    output logic [N-1:0]                         alu_in1,
    output logic [N-1:0]                         alu_in2,
    output logic [1:0]                           alu_op,
    input  logic [N-1:0]                         alu_out,
    input  logic                                 alu_z,
    output logic                                 done,
    output logic                                 zflag,
    input  logic [REG_ADDR_W-1:0]                dbg_addr,
    output logic [N-1:0]                         dbg_data,
    output logic [15:0]                          perf_count
);

    localparam int RS1_LSB = rs1_lsb(REG_ADDR_W);
    localparam int RD_LSB  = rd_lsb(REG_ADDR_W);
    localparam int OP_LSB  = op_lsb(REG_ADDR_W);
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

    issue_state_e          state_q, state_d;
    logic [N-1:0]          alu_in1_q, alu_in1_d;
    logic [N-1:0]          alu_in2_q, alu_in2_d;
    logic [1:0]            alu_op_q, alu_op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  zflag_q, zflag_d;

    logic [REG_ADDR_W-1:0] instr_rs1, instr_rs2, instr_rd;
    logic [1:0]            instr_op;
    logic [N-1:0]          rs1_data, rs2_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [N-1:0]          rf_wdata;

    assign instr_rs2 = instr[0 +: REG_ADDR_W];
    assign instr_rs1 = instr[RS1_LSB +: REG_ADDR_W];
    assign instr_rd  = instr[RD_LSB +: REG_ADDR_W];
    assign instr_op  = instr[OP_LSB +: 2];

    // A pending instruction always beats a preload in IDLE.
    assign instr_ready = (state_q == IDLE);
    assign ld_ready    = (state_q == IDLE) && !instr_valid;

    assign rf_we    = (state_q == WB) || (ld_en && ld_ready);
    assign rf_waddr = (state_q == WB) ? rd_q : ld_addr;
    assign rf_wdata = (state_q == WB) ? alu_out : ld_data;

    alu_regfile #(
        .N      (N),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .rstn       (rstn),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .raddr1_i   (instr_rs1),
        .rdata1_o   (rs1_data),
        .raddr2_i   (instr_rs2),
        .rdata2_o   (rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // WAIT lasts exactly ALU_LAT cycles: the counter starts at ALU_LAT-1.
    always_comb begin
        state_d   = state_q;
        alu_in1_d = alu_in1_q;
        alu_in2_d = alu_in2_q;
        alu_op_d  = alu_op_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        zflag_d   = zflag_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d   = WAIT;
                    alu_in1_d = rs1_data;
                    alu_in2_d = rs2_data;
                    alu_op_d  = instr_op;
                    rd_d      = instr_rd;
                    cnt_d     = LAT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WB: begin
                state_d = IDLE;
                done_d  = 1'b1;
                zflag_d = alu_z;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
            alu_op_q  <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            zflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_in1_q <= alu_in1_d;
            alu_in2_q <= alu_in2_d;
            alu_op_q  <= alu_op_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            zflag_q   <= zflag_d;
        end
    end

    assign alu_in1 = alu_in1_q;
    assign alu_in2 = alu_in2_q;
    assign alu_op  = alu_op_q;
    assign done    = done_q;
    assign zflag   = zflag_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    assign perf_d = (state_q == WB) ? perf_q + 16'd1 : perf_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`else
    assign perf_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU feeds the DUT and a
// register-array reference model predicts writebacks, flags and timing.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int N   = 12;
    localparam int AW  = 3;
    localparam int LAT = 1;
    localparam int IW  = 2 + 3 * AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic          ld_en;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [N-1:0]  ld_data;
    logic [N-1:0]  alu_in1, alu_in2;
    logic [1:0]    alu_op;
    logic [N-1:0]  alu_out;
    logic          alu_z;
    logic          done;
    logic          zflag;
    logic [AW-1:0] dbg_addr;
    logic [N-1:0]  dbg_data;
    logic [15:0]   perf_count;

    int errors = 0;
    int checks = 0;
    int retired = 0;
    logic [N-1:0] refRegs [2**AW];
    logic [N-1:0] aluPipe [LAT];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N), .REG_ADDR_W(AW), .ALU_LAT(LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_z       (alu_z),
        .done        (done),
        .zflag       (zflag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .perf_count  (perf_count)
    );

    function automatic logic [N-1:0] aluRef(input logic [1:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [2*N-1:0] prod;
        prod = a * b;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return prod[N-1:0];
            default: return a;
        endcase
    endfunction

    // Behavioural clocked ALU with LAT register stages.
    always @(posedge clk) begin
        aluPipe[0] <= aluRef(alu_op, alu_in1, alu_in2);
        for (int i = 1; i < LAT; i++) aluPipe[i] <= aluPipe[i-1];
    end
    assign alu_out = aluPipe[LAT-1];
    assign alu_z   = (aluPipe[LAT-1] == '0);

    function automatic logic [IW-1:0] mkInstr(input logic [1:0] op, input int rd,
                                              input int rs1, input int rs2);
        logic [AW-1:0] d, s1, s2;
        d = rd[AW-1:0]; s1 = rs1[AW-1:0]; s2 = rs2[AW-1:0];
        return {op, d, s1, s2};
    endfunction

    function automatic logic [15:0] expPerf();
`ifdef ALU_ISSUE_PERF_CNT_EN
        return 16'(retired);
`else
        return 16'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkReg(input string tag, input int addr);
        dbg_addr = addr[AW-1:0];
        #1;
        checkOutput(tag, dbg_data, refRegs[addr]);
    endtask

    task automatic preload(input int addr, input logic [N-1:0] data);
        ld_en = 1'b1; ld_addr = addr[AW-1:0]; ld_data = data; instr_valid = 1'b0;
        #1;
        checkOutput("ld_ready_idle", ld_ready, 1'b1);
        @(negedge clk);
        ld_en = 1'b0;
        refRegs[addr] = data;
    endtask

    // Issues one instruction from IDLE and follows it through to retirement.
    task automatic applyStimulus(input logic [1:0] op, input int rd, input int rs1, input int rs2);
        logic [N-1:0] a, b, r;
        int cyc;
        a = refRegs[rs1]; b = refRegs[rs2]; r = aluRef(op, a, b);
        checkOutput("ready_idle", instr_ready, 1'b1);
        instr = mkInstr(op, rd, rs1, rs2);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("alu_in1", alu_in1, a);
        checkOutput("alu_in2", alu_in2, b);
        checkOutput("alu_op", alu_op, op);
        cyc = 0;
        while (!done && cyc < 20) begin
            checkOutput("ready_busy", instr_ready, 1'b0);
            @(negedge clk);
            cyc++;
        end
        checkOutput("done_latency", cyc, LAT + 1);
        refRegs[rd] = r;
        retired++;
        checkOutput("zflag", zflag, (r == '0));
        checkOutput("perf_count", perf_count, expPerf());
        checkReg("writeback", rd);
        @(negedge clk);
        checkOutput("done_pulse", done, 1'b0);
    endtask

    initial begin
        int accepts, dones, ldWrites, ldBusy, ldConflict, t;
        int accT [2];
        int doneT [2];

        rstn = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; dbg_addr = '0;
        for (int i = 0; i < 2**AW; i++) refRegs[i] = '0;
        for (int i = 0; i < LAT; i++) aluPipe[i] = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in1", alu_in1, 0);
        checkOutput("rst_op", alu_op, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_zflag", zflag, 0);
        checkOutput("rst_perf", perf_count, 0);
        checkOutput("rst_ready", instr_ready, 1);
        rstn = 1'b1;
        @(negedge clk);

        // Directed: ADD with plain operands, then SUB producing zero.
        preload(1, 12'd5); preload(2, 12'd10);
        applyStimulus(ALU_ADD, 3, 1, 2);
        preload(4, 12'd30); preload(5, 12'd30);
        applyStimulus(ALU_SUB, 6, 4, 5);

        // Back-to-back with instr_valid held: R1 = 3 -> 6 -> 12.
        preload(1, 12'd3);
        instr = mkInstr(ALU_ADD, 1, 1, 1);
        instr_valid = 1'b1;
        accepts = 0; dones = 0; t = 0;
        while (dones < 2 && t < 40) begin
            #1;
            if (instr_valid && instr_ready && accepts < 2) begin accT[accepts] = t; accepts++; end
            @(negedge clk);
            t++;
            if (accepts == 2) instr_valid = 1'b0;
            if (done) begin doneT[dones] = t; dones++; end
        end
        checkOutput("b2b_dones", dones, 2);
        checkOutput("b2b_accept_gap", accT[1] - accT[0], LAT + 2);
        checkOutput("b2b_done_gap", doneT[1] - doneT[0], LAT + 2);
        refRegs[1] = 12'd12;
        retired += 2;
        checkReg("b2b_r1", 1);
        @(negedge clk);

        // Preload held while busy, plus a competing held instruction.
        instr = mkInstr(ALU_ADD, 3, 1, 2);
        instr_valid = 1'b1;
        @(negedge clk);
        instr = mkInstr(ALU_SUB, 4, 3, 1);
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 12'hABC;
        accepts = 1; dones = 0; ldWrites = 0; ldBusy = 0; ldConflict = 0; t = 0;
        while ((ldWrites == 0 || dones < 2) && t < 40) begin
            #1;
            if (ld_ready && instr_valid) ldConflict++;
            if (ld_ready && !instr_ready) ldBusy++;
            if (instr_valid && instr_ready) accepts++;
            if (ld_en && ld_ready) ldWrites++;
            @(negedge clk);
            t++;
            if (accepts == 2) instr_valid = 1'b0;
            if (ldWrites > 0) ld_en = 1'b0;
            if (done) dones++;
        end
        refRegs[3] = aluRef(ALU_ADD, refRegs[1], refRegs[2]);
        refRegs[4] = aluRef(ALU_SUB, refRegs[3], refRegs[1]);
        refRegs[7] = 12'hABC;
        retired += 2;
        checkOutput("ld_accepts", accepts, 2);
        checkOutput("ld_writes", ldWrites, 1);
        checkOutput("ld_while_busy", ldBusy, 0);
        checkOutput("ld_vs_instr", ldConflict, 0);
        checkOutput("ld_perf", perf_count, expPerf());
        checkReg("ld_r3", 3);
        checkReg("ld_r4", 4);
        checkReg("ld_r7", 7);
        @(negedge clk);

        // Randomized mix of preloads and instructions.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0)
                preload(int'($urandom_range(0, 7)), N'($urandom));
            else
                applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 2**AW; i++) checkReg("sweep", i);

        // Reset during WAIT aborts MUL r2,r1,r1.
        preload(1, 12'd4);
        instr = mkInstr(ALU_MUL, 2, 1, 1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 2**AW; i++) refRegs[i] = '0;
        retired = 0;
        checkOutput("abort_ready", instr_ready, 1);
        checkOutput("abort_in1", alu_in1, 0);
        checkOutput("abort_in2", alu_in2, 0);
        checkOutput("abort_op", alu_op, 0);
        checkOutput("abort_zflag", zflag, 0);
        checkOutput("abort_perf", perf_count, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_no_done", done, 0);
            @(negedge clk);
        end
        checkReg("abort_r2", 2);
        checkReg("abort_r1", 1);

        // Three retirements after reset.
        preload(1, 12'd1);
        applyStimulus(ALU_ADD, 2, 1, 1);
        applyStimulus(ALU_SUB, 3, 2, 1);
        applyStimulus(ALU_PASS, 4, 3, 0);
`ifdef ALU_ISSUE_PERF_CNT_EN
        checkOutput("perf_final", perf_count, 3);
`else
        checkOutput("perf_final", perf_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
